// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES segments of WIDTH/STAGES bits each.
// Latency is STAGES cycles from accept to out_valid. Throughput is one operation per cycle.
// Backpressure uses one global advance, adv = ~out_valid | out_ready. When adv=0 every stage holds, and in_ready = adv.
//
// Ports:
//   clk, rst_n                      clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready               operation handshake
//   in_a, in_b                      operands
//   in_sub/in_signed/in_sat         mode bits: subtract, signed overflow rules, saturate
//   out_valid/out_ready             result handshake
//   out_sum, out_cout, out_ov       result (saturated if requested), raw carry out, overflow flag
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ov
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage pipeline registers. Stage k holds the operands (B already
  // conditioned for subtract), the sum bits resolved so far, the carry out
  // of its segment and the mode bits that travel with the operation.
  logic [STAGES-1:0] vld_q, sub_q, sgn_q, sat_q, cy_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              cmsb_q;   // carry into the MSB, captured by the final stage

  logic [STAGES-1:0] nx_vld, nx_sub, nx_sgn, nx_sat, nx_cy;
  logic [WIDTH-1:0]  nx_a   [STAGES];
  logic [WIDTH-1:0]  nx_b   [STAGES];
  logic [WIDTH-1:0]  nx_sum [STAGES];
  logic              nx_cmsb;

  logic              adv;

  // Scratch values for the segment being evaluated.
  logic [WIDTH-1:0]  ta, tb, ts;
  logic              tc;
  logic [SEG-1:0]    gg, pp;
  logic [SEG:0]      c;
  logic              grp_g, grp_p;
  int                km1;

  assign adv      = ~vld_q[LAST] | out_ready;
  assign in_ready = adv;

  always_comb begin
    nx_vld  = '0;
    nx_sub  = '0;
    nx_sgn  = '0;
    nx_sat  = '0;
    nx_cy   = '0;
    nx_cmsb = 1'b0;
    ta      = '0;
    tb      = '0;
    ts      = '0;
    tc      = 1'b0;
    gg      = '0;
    pp      = '0;
    c       = '0;
    grp_g   = 1'b0;
    grp_p   = 1'b1;
    km1     = 0;
    for (int k = 0; k < STAGES; k++) begin
      nx_a[k]   = '0;
      nx_b[k]   = '0;
      nx_sum[k] = '0;
    end

    for (int k = 0; k < STAGES; k++) begin
      km1 = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        // Subtract is A + ~B + 1. The +1 enters as the chain's carry-in.
        ta        = in_a;
        tb        = in_b ^ {WIDTH{in_sub}};
        ts        = '0;
        tc        = in_sub;
        nx_vld[k] = in_valid;
        nx_sub[k] = in_sub;
        nx_sgn[k] = in_signed;
        nx_sat[k] = in_sat;
      end else begin
        ta        = a_q[km1];
        tb        = b_q[km1];
        ts        = sum_q[km1];
        tc        = cy_q[km1];
        nx_vld[k] = vld_q[km1];
        nx_sub[k] = sub_q[km1];
        nx_sgn[k] = sgn_q[km1];
        nx_sat[k] = sat_q[km1];
      end

      // Segment lookahead. The running group generate/propagate for bits
      // [i:0] gives every carry directly from the segment carry-in.
      gg    = ta[k*SEG +: SEG] & tb[k*SEG +: SEG];
      pp    = ta[k*SEG +: SEG] ^ tb[k*SEG +: SEG];
      grp_g = 1'b0;
      grp_p = 1'b1;
      c[0]  = tc;
      for (int i = 0; i < SEG; i++) begin
        grp_g  = gg[i] | (pp[i] & grp_g);
        grp_p  = pp[i] & grp_p;
        c[i+1] = grp_g | (grp_p & tc);
      end
      ts[k*SEG +: SEG] = pp ^ c[SEG-1:0];

      nx_a[k]   = ta;
      nx_b[k]   = tb;
      nx_sum[k] = ts;
      nx_cy[k]  = c[SEG];
      if (k == LAST) begin
        nx_cmsb = c[SEG-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sub_q  <= '0;
      sgn_q  <= '0;
      sat_q  <= '0;
      cy_q   <= '0;
      cmsb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= nx_vld;
      sub_q  <= nx_sub;
      sgn_q  <= nx_sgn;
      sat_q  <= nx_sat;
      cy_q   <= nx_cy;
      cmsb_q <= nx_cmsb;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= nx_a[k];
        b_q[k]   <= nx_b[k];
        sum_q[k] <= nx_sum[k];
      end
    end
  end

  // Overflow and saturation are computed from the final registers, so the
  // outputs hold naturally while the pipeline is stalled. The reset values
  // of these registers also give the required all-zero outputs.
  logic             fin_cout, fin_ov, fin_sub, fin_sgn, fin_sat, a_msb;
  logic [WIDTH-1:0] sat_val;

  always_comb begin
    fin_cout = cy_q[LAST];
    fin_sub  = sub_q[LAST];
    fin_sgn  = sgn_q[LAST];
    fin_sat  = sat_q[LAST];
    a_msb    = a_q[LAST][WIDTH-1];
    if (fin_sgn) begin
      fin_ov = fin_cout ^ cmsb_q;
    end else begin
      // An unsigned subtract borrows when there is no carry out.
      fin_ov = fin_sub ? ~fin_cout : fin_cout;
    end
    if (fin_sgn) begin
      // A signed overflow always has the sign of A, so clamp toward that side.
      sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat_val = fin_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_cout  = fin_cout;
  assign out_ov    = fin_ov;
  assign out_sum   = (fin_sat && fin_ov) ? sat_val : sum_q[LAST];

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_a, in_b;
  logic        in_sub, in_signed, in_sat;
  logic        iv   [3];
  logic        ir   [3];
  logic        ovl  [3];
  logic        ordy [3];
  logic        oco  [3];
  logic        oov  [3];
  logic [31:0] s0, s1;
  logic [15:0] s2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(32), .STAGES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(ovl[0]), .out_ready(ordy[0]), .out_sum(s0), .out_cout(oco[0]), .out_ov(oov[0]));

  addsub_pipe #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(ovl[1]), .out_ready(ordy[1]), .out_sum(s1), .out_cout(oco[1]), .out_ov(oov[1]));

  addsub_pipe #(.WIDTH(16), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(ovl[2]), .out_ready(ordy[2]), .out_sum(s2), .out_cout(oco[2]), .out_ov(oov[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_sum(input int d);
    case (d)
      0:       return s0;
      1:       return s1;
      default: return {16'h0, s2};
    endcase
  endfunction

  // Reference model: works on whole numbers rather than carries.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sgn, input logic sat,
                       output logic [31:0] s, output logic co, output logic ovf);
    longint mask, ua, ub, full, raw, sa, sb, r, hi, lo, satv;
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'h0, a}) & mask;
    ub   = longint'({32'h0, b}) & mask;
    if (sub) begin
      co  = (ua >= ub);
      raw = (ua - ub) & mask;
    end else begin
      full = ua + ub;
      co   = ((full >> w) & 1) != 0;
      raw  = full & mask;
    end
    if (sgn) begin
      hi   = (longint'(1) << (w - 1)) - 1;
      lo   = -(hi + 1);
      sa   = (ua > hi) ? ua - (mask + 1) : ua;
      sb   = (ub > hi) ? ub - (mask + 1) : ub;
      r    = sub ? sa - sb : sa + sb;
      ovf  = (r > hi) || (r < lo);
      satv = (r > hi) ? hi : (lo & mask);
    end else begin
      ovf  = sub ? !co : co;
      satv = sub ? 0 : mask;
    end
    s = (sat && ovf) ? satv[31:0] : raw[31:0];
  endtask

  task automatic run_op(input int d, input int w, input int stages,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sgn, input logic sat, input string tag);
    logic [31:0] es;
    logic        ec, eo;
    int          n;
    model(w, a, b, sub, sgn, sat, es, ec, eo);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_signed = sgn; in_sat = sat;
    iv[d] = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(ir[d]), 64'd1);
    @(negedge clk);
    iv[d] = 1'b0;
    n = 1;
    while (!ovl[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(stages));
    check({tag, ".sum"}, 64'(get_sum(d)), 64'(es));
    check({tag, ".cout"}, 64'(oco[d]), 64'(ec));
    check({tag, ".ov"}, 64'(oov[d]), 64'(eo));
  endtask

  task automatic run_suite(input int d, input int w, input int stages, input string pfx);
    logic [31:0] mask, smax, smin;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    smax = mask >> 1;
    smin = smax + 1;
    run_op(d, w, stages, 32'd3, 32'd10, 1'b0, 1'b0, 1'b0, {pfx, ".uadd"});
    run_op(d, w, stages, 32'd3, 32'd10, 1'b1, 1'b0, 1'b0, {pfx, ".usub"});
    run_op(d, w, stages, 32'd3, 32'd10, 1'b1, 1'b0, 1'b1, {pfx, ".usub_sat"});
    run_op(d, w, stages, mask, 32'd1, 1'b0, 1'b0, 1'b1, {pfx, ".uadd_sat"});
    run_op(d, w, stages, smax, 32'd1, 1'b0, 1'b1, 1'b0, {pfx, ".sadd_ov"});
    run_op(d, w, stages, smax, 32'd1, 1'b0, 1'b1, 1'b1, {pfx, ".sadd_sat"});
    run_op(d, w, stages, smin, 32'd1, 1'b1, 1'b1, 1'b1, {pfx, ".ssub_sat"});
    run_op(d, w, stages, mask, 32'd5, 1'b1, 1'b1, 1'b0, {pfx, ".ssub_neg"});
    run_op(d, w, stages, mask, 32'd5, 1'b0, 1'b1, 1'b0, {pfx, ".sadd_neg"});
  endtask

  initial begin
    logic [33:0] q[$];
    logic [33:0] prev_out, cur_out, exp_out;
    logic [4:0]  pat;
    logic [31:0] es;
    logic        ec, eo, prev_stall, seen;
    int          sent, got, cyc, n;

    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    in_a = '0; in_b = '0; in_sub = 1'b0; in_signed = 1'b0; in_sat = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.out_valid", 64'(ovl[0]), 64'd0);
    check("reset.out_sum", 64'(s0), 64'd0);
    check("reset.out_cout", 64'(oco[0]), 64'd0);
    check("reset.out_ov", 64'(oov[0]), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset.in_ready", 64'(ir[0]), 64'd1);

    // Directed cases on all three configurations
    run_suite(0, 32, 4, "w32s4");
    run_suite(1, 32, 1, "w32s1");
    run_suite(2, 16, 2, "w16s2");

    // Random stream under a 1,0,0,1,0 out_ready pattern
    pat = 5'b01001;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      ordy[0] = pat[cyc % 5];
      #1;
      check("stream.in_ready", 64'(ir[0]), 64'(!(ovl[0] && !ordy[0])));
      cur_out = {oov[0], oco[0], s0};
      if (prev_stall && ovl[0]) begin
        check("stream.hold", 64'(cur_out), 64'(prev_out));
      end
      if (ovl[0] && ordy[0]) begin
        if (q.size() > 0) begin
          exp_out = q.pop_front();
          check("stream.result", 64'(cur_out), 64'(exp_out));
        end else begin
          check("stream.spurious", 64'(ovl[0]), 64'd0);
        end
        got++;
      end
      prev_stall = ovl[0] && !ordy[0];
      prev_out   = cur_out;
      if (sent < 16 && ir[0]) begin
        in_a      = $urandom;
        in_b      = $urandom;
        in_sub    = 1'($urandom_range(0, 1));
        in_signed = 1'($urandom_range(0, 1));
        in_sat    = 1'($urandom_range(0, 1));
        iv[0]     = 1'b1;
        model(32, in_a, in_b, in_sub, in_signed, in_sat, es, ec, eo);
        q.push_back({eo, ec, es});
        sent++;
      end else begin
        iv[0] = 1'b0;
      end
      cyc++;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    check("stream.count", 64'(got), 64'd16);

    // Reset asserted with three operations in flight
    repeat (3) @(negedge clk);
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 32'(i + 1); in_b = 32'd7; in_sub = 1'b0; in_signed = 1'b0; in_sat = 1'b0;
      iv[0] = 1'b1;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ovl[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midrst.pre_valid", 64'(ovl[0]), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 64'(ovl[0]), 64'd0);
    check("midrst.out_sum", 64'(s0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ovl[0]) seen = 1'b1;
    end
    check("midrst.no_stale", 64'(seen), 64'd0);
    check("midrst.in_ready", 64'(ir[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit. It is the successor to the team's combinational 32-bit carry-lookahead adder. The carry chain is split into STAGES registered segments, and the block adds a valid/ready handshake with backpressure, per-operation mode bits (sub, signed, saturate) and saturating results. It sits in the execute path wherever a multi-cycle, high-Fmax adder is needed.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, number of pipeline stages (>=1); each stage resolves WIDTH/STAGES bits (SEG) of the carry chain.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_sub  in  1  1 = A-B, 0 = A+B
in_signed  in  1  1 = two's-complement overflow rules, 0 = unsigned
in_sat  in  1  1 = clamp result on overflow
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH  result (saturated if requested)
out_cout  out  1  raw carry out of the MSB (before saturation)
out_ov  out  1  overflow flag per mode

Behaviour:
- Reset (rst_n=0, asynchronous): every stage valid bit is cleared. out_valid=0, out_sum=0, out_cout=0, out_ov=0. in_ready=1 as soon as reset is released.
- Reset mid-operation: all in-flight operations are discarded, with no partial output.
- Transfer rules: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv.
- When adv=0 every pipeline register holds. When adv=1 every stage shifts by one, and bubbles propagate as valid=0.
- Latency: a result accepted in cycle t is presented with out_valid=1 in cycle t+STAGES, absent stalls. Throughput is one op/cycle.
- Input preparation: B' = in_b XOR {WIDTH{in_sub}}. Carry-in c0 = in_sub.
- Stage k (0..STAGES-1) computes sum bits [k*SEG +: SEG] from A, B' and the carry registered by stage k-1 (c0 for k=0), using lookahead within the segment.
- Unresolved upper operand bits and the mode bits are skewed forward in pipeline registers. Resolved sum bits are carried to the output.
- Final stage also registers c[WIDTH] (cout) and c[WIDTH-1] (carry into MSB).
- Overflow:
  - signed: ov = c[WIDTH] ^ c[WIDTH-1].
  - unsigned add: ov = cout.
  - unsigned sub: ov = ~cout (borrow).
- Saturation applies only when in_sat=1 and ov=1; otherwise out_sum is the raw wrapped sum:
  - signed: clamp to 0 1...1 if A's MSB = 0, or 1 0...0 if A's MSB = 1.
  - unsigned add: all ones.
  - unsigned sub: all zeros.
- out_cout is always the raw carry. out_ov reports overflow regardless of in_sat.
- Ordering: results leave in acceptance order, with no loss or duplication under any out_ready pattern.
- Output stability: while out_valid=1 and out_ready=0, out_sum, out_cout and out_ov hold stable.
- STAGES=1: the block degenerates to a single registered adder with latency 1. The same handshake applies.
- Simultaneous accept/emit with a full pipeline and out_ready=1 is legal every cycle.

Test Plan:
1. WIDTH=32, STAGES=4. Unsigned add 3+10, out_ready=1 → out_sum=13, cout=0, ov=0. out_valid exactly 4 cycles after accept.
2. Unsigned sub 3-10:
   - sat=0 → out_sum=0xFFFFFFF9, cout=0, ov=1.
   - sat=1 → out_sum=0x00000000, ov=1.
   - Unsigned add 0xFFFFFFFF+1 with sat=1 → out_sum=0xFFFFFFFF, cout=1, ov=1.
3. Signed add 0x7FFFFFFF+1:
   - sat=0 → 0x80000000, ov=1.
   - sat=1 → 0x7FFFFFFF.
   - Signed sub 0x80000000-1 with sat=1 → 0x80000000, ov=1.
4. Signed 0xFFFFFFFF-5 → out_sum=0xFFFFFFFA, cout=1, ov=0. Signed 0xFFFFFFFF+5 → 0x00000004, cout=1, ov=0.
5. Stream 16 random ops back-to-back while out_ready follows a 1,0,0,1,0 pattern:
   - results match the reference model in order;
   - in_ready=0 exactly when out_valid=1 and out_ready=0;
   - outputs stable across stalls.
6. Reset and parameter sweep:
   - assert rst_n=0 mid-stream with 3 ops in flight → out_valid drops immediately; after release, no stale result emerges.
   - repeat tests 1–4 with STAGES=1 and with WIDTH=16, STAGES=2.
